// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory responder.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD_DATA,
    WR_DATA,
    IGNORE
  } spi_mem_state_t;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings cs_n, spi_sclk and spi_mosi into the clk domain. Emits one-cycle
// rise/fall pulses for SCLK three clk after the pin edge, plus a cs_n fall
// pulse. MOSI gets one more stage so that it lines up with the rise pulse.
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic cs_n,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic cs_n_s,
  output logic cs_fall,
  output logic mosi_s,
  output logic rise,
  output logic fall
);

  logic cs_p0, cs_p1, cs_p2;
  logic sclk_p0, sclk_p1, sclk_p2;
  logic mosi_p0, mosi_p1, mosi_p2;

  // Control synchronizers and registered edge pulses; idle as deselected, SCLK low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      cs_p2   <= 1'b1;
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      cs_fall <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability filter
      cs_p0   <= cs_n;
      cs_p1   <= cs_p0;
      sclk_p0 <= spi_sclk;
      sclk_p1 <= sclk_p0;
      // stage p1 -> p2: history for edge detection
      cs_p2   <= cs_p1;
      sclk_p2 <= sclk_p1;
      rise    <= sclk_p1 & ~sclk_p2;
      fall    <= ~sclk_p1 & sclk_p2;
      cs_fall <= ~cs_p1 & cs_p2;
    end
  end

  // MOSI data path, three stages so it is valid and stable when rise is seen.
  always_ff @(posedge clk) begin
    mosi_p0 <= spi_mosi;
    mosi_p1 <= mosi_p0;
    mosi_p2 <= mosi_p1;
  end

  assign cs_n_s = cs_p1;
  assign mosi_s = mosi_p2;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory responder: READ (0x03) / WRITE (0x02) with 24-bit
// address, served from an internal byte array with a backdoor load port.
// Build option: define SPI_MEM_WRITE_EN to accept the WRITE command;
// otherwise the array is read-only over SPI (0x02 is ignored).
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 65536,
  parameter int ADDR_W      = $clog2(DEPTH_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              miso_oe,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              busy,
  output logic [15:0]       cmd_count
);

  logic cs_n_s, cs_fall, mosi_s, rise, fall;

  spi_edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .cs_n     (cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .cs_n_s   (cs_n_s),
    .cs_fall  (cs_fall),
    .mosi_s   (mosi_s),
    .rise     (rise),
    .fall     (fall)
  );

  spi_mem_state_t    state;
  logic [4:0]        bit_cnt;
  logic [7:0]        sh;
  logic [7:0]        sh_in;
  logic [ADDR_W-2:0] addr_sh;
  logic [ADDR_W-1:0] addr, addr_full, addr_nxt;
  logic [7:0]        mem [DEPTH_BYTES];

  logic sel, cmd_rise, addr_rise, addr_done, rd_fall, rd_last;

  // Only the low ADDR_W bits of the 24-bit bus address are kept.
  assign sh_in     = {sh[6:0], mosi_s};
  assign addr_full = {addr_sh, mosi_s};
  assign addr_nxt  = addr + ADDR_W'(1);

  assign sel       = ~cs_n_s;
  assign cmd_rise  = sel & rise & (state == CMD);
  assign addr_rise = sel & rise & (state == ADDR);
  assign addr_done = addr_rise & (bit_cnt == 5'(ADDR_BITS - 1));
  assign rd_fall   = sel & fall & (state == RD_DATA);
  assign rd_last   = rd_fall & (bit_cnt == 5'd7);

`ifdef SPI_MEM_WRITE_EN
  logic is_wr, wr_rise, wr_done;
  assign wr_rise = sel & rise & (state == WR_DATA);
  assign wr_done = wr_rise & (bit_cnt == 5'd7);
`endif

  // Command FSM with registered outputs; deselect overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      miso_oe   <= 1'b0;
      spi_miso  <= 1'b0;
      cmd_count <= '0;
`ifdef SPI_MEM_WRITE_EN
      is_wr     <= 1'b0;
`endif
    end else if (cs_n_s) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      miso_oe  <= 1'b0;
      spi_miso <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= CMD;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        CMD: begin
          if (rise) begin
            if (bit_cnt == 5'(CMD_BITS - 1)) begin
              bit_cnt <= '0;
              if (sh_in == SPI_CMD_READ) begin
                state <= ADDR;
`ifdef SPI_MEM_WRITE_EN
                is_wr <= 1'b0;
              end else if (sh_in == SPI_CMD_WRITE) begin
                state <= ADDR;
                is_wr <= 1'b1;
`endif
              end else begin
                state <= IGNORE;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        ADDR: begin
          if (rise) begin
            if (bit_cnt == 5'(ADDR_BITS - 1)) begin
              bit_cnt   <= '0;
              cmd_count <= cmd_count + 16'd1;
              state     <= RD_DATA;
              miso_oe   <= 1'b1;
`ifdef SPI_MEM_WRITE_EN
              if (is_wr) begin
                state   <= WR_DATA;
                miso_oe <= 1'b0;
              end
`endif
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        RD_DATA: begin
          if (fall) begin
            spi_miso <= sh[7];
            bit_cnt  <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
          end
        end
`ifdef SPI_MEM_WRITE_EN
        WR_DATA: begin
          if (rise) begin
            bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Shift register and address path; the next read byte is fetched on the last fall.
  always_ff @(posedge clk) begin
    if (cmd_rise) begin
      sh <= sh_in;
    end else if (addr_done) begin
      sh <= mem[addr_full];
    end else if (rd_fall) begin
      sh <= rd_last ? mem[addr_nxt] : {sh[6:0], 1'b0};
`ifdef SPI_MEM_WRITE_EN
    end else if (wr_rise) begin
      sh <= sh_in;
`endif
    end

    if (addr_rise) addr_sh <= addr_full[ADDR_W-2:0];

    if (addr_done) begin
      addr <= addr_full;
    end else if (rd_last) begin
      addr <= addr_nxt;
`ifdef SPI_MEM_WRITE_EN
    end else if (wr_done) begin
      addr <= addr_nxt;
`endif
    end
  end

  // Backing array; the backdoor port wins over a same-cycle SPI write.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
`ifdef SPI_MEM_WRITE_EN
    end else if (wr_done) begin
      mem[addr] <= sh_in;
`endif
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder (DEPTH_BYTES = 256). Stimulus queues the bytes
// a read should return; a monitor collects MISO bits while miso_oe is high
// and compares each completed byte against the queue.
module tb_spi_mem_responder;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

`ifdef SPI_MEM_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          cs_n      = 1'b1;
  logic          spi_sclk  = 1'b0;
  logic          spi_mosi  = 1'b0;
  logic          load_en   = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [7:0]    load_data = '0;
  logic          spi_miso, miso_oe, busy;
  logic [15:0]   cmd_count;

  int          n_cmp   = 0;
  int          n_err   = 0;
  logic [15:0] exp_cmd = '0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  spi_mem_responder #(.DEPTH_BYTES(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .miso_oe   (miso_oe),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy),
    .cmd_count (cmd_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: master-side sampling late in the SCLK high phase.
  initial begin : monitor
    logic       oe_r;
    logic [7:0] rx;
    int         nb;
    rx = '0;
    nb = 0;
    forever begin
      @(posedge spi_sclk);
      oe_r = miso_oe;
      #30;
      if (!oe_r) begin
        nb = 0;
      end else begin
        rx = {rx[6:0], spi_miso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL miso_byte: got 0x%02h, nothing expected", rx);
          end else begin
            check("miso_byte", 32'(rx), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  task automatic sbit(input logic b);
    spi_mosi = b;
    #40 spi_sclk = 1'b1;
    #40 spi_sclk = 1'b0;
  endtask

  task automatic sbyte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sbit(b[3'(i)]);
  endtask

  task automatic sel_on();
    cs_n = 1'b0;
    #80;
  endtask

  task automatic sel_off();
    #40 cs_n = 1'b1;
    #200;
  endtask

  task automatic spi_read(input logic [23:0] a, input logic [7:0] e0, input logic [7:0] e1,
                          input string tag);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    sel_on();
    sbyte(8'h03);
    check({tag, "_oe_cmd"}, 32'(miso_oe), 32'd0);
    sbyte(a[23:16]);
    sbyte(a[15:8]);
    sbyte(a[7:0]);
    exp_cmd = exp_cmd + 16'd1;
    check({tag, "_oe_data"}, 32'(miso_oe), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_cmd_count"}, 32'(cmd_count), 32'(exp_cmd));
    sbyte(8'h00);
    sbyte(8'h00);
    sel_off();
    check({tag, "_oe_idle"}, 32'(miso_oe), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin : stim
    logic [7:0] pb;
    #20;
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_count", 32'(cmd_count), 32'd0);
    rst = 1'b0;
    #100;

    // basic read of two consecutive bytes
    load(8'h10, 8'hA5);
    load(8'h11, 8'h3C);
    spi_read(24'h000010, 8'hA5, 8'h3C, "read");

    // address bits above ADDR_W are ignored
    spi_read(24'h123410, 8'hA5, 8'h3C, "hiaddr");

    // read wraps from the top of the array to 0
    load(8'hFF, 8'h11);
    load(8'h00, 8'h22);
    spi_read(24'h0000FF, 8'h11, 8'h22, "wrap");

    // write then read back (unchanged when writes are not built)
    load(8'h20, 8'h55);
    load(8'h21, 8'h66);
    sel_on();
    sbyte(8'h02); sbyte(8'h00); sbyte(8'h00); sbyte(8'h20);
    sbyte(8'hDE); sbyte(8'hAD);
    sel_off();
    if (WR_EN) exp_cmd = exp_cmd + 16'd1;
    check("write_cmd_count", 32'(cmd_count), 32'(exp_cmd));
    spi_read(24'h000020, WR_EN ? 8'hDE : 8'h55, WR_EN ? 8'hAD : 8'h66, "wr_rb");

    // unknown command is ignored until deselect
    sel_on();
    sbyte(8'h9F);
    check("unk_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      sbyte(8'h00);
      check("unk_oe", 32'(miso_oe), 32'd0);
    end
    sel_off();
    check("unk_cmd_count", 32'(cmd_count), 32'(exp_cmd));
    spi_read(24'h000010, 8'hA5, 8'h3C, "after_unk");

    // deselect after half a write byte leaves memory untouched
    load(8'h30, 8'h77);
    load(8'h31, 8'h88);
    sel_on();
    sbyte(8'h02); sbyte(8'h00); sbyte(8'h00); sbyte(8'h30);
    if (WR_EN) exp_cmd = exp_cmd + 16'd1;
    sbit(1'b1); sbit(1'b0); sbit(1'b1); sbit(1'b0);
    sel_off();
    check("abort_cmd_count", 32'(cmd_count), 32'(exp_cmd));
    spi_read(24'h000030, 8'h77, 8'h88, "abort");

    // backdoor load lands in the same cycle as the SPI write of byte 0x99
    sel_on();
    sbyte(8'h02); sbyte(8'h00); sbyte(8'h00); sbyte(8'h40);
    if (WR_EN) exp_cmd = exp_cmd + 16'd1;
    pb = 8'h99;
    for (int i = 7; i >= 1; i--) sbit(pb[3'(i)]);
    spi_mosi = pb[0];
    #40 spi_sclk = 1'b1;
    #30;
    load_en   = 1'b1;
    load_addr = 8'h40;
    load_data = 8'h42;
    #10;
    load_en   = 1'b0;
    spi_sclk  = 1'b0;
    sel_off();
    load(8'h41, 8'h5A);
    spi_read(24'h000040, 8'h42, 8'h5A, "prio");

    // reset in the middle of a read data byte
    sel_on();
    sbyte(8'h03); sbyte(8'h00); sbyte(8'h00); sbyte(8'h10);
    sbit(1'b0);
    sbit(1'b0);
    #40;
    check("pre_rst_miso", 32'(spi_miso), 32'd1);
    check("pre_rst_oe", 32'(miso_oe), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_miso", 32'(spi_miso), 32'd0);
    check("midrst_oe", 32'(miso_oe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cmd_count", 32'(cmd_count), 32'd0);
    cs_n = 1'b1;
    #39;
    rst     = 1'b0;
    exp_cmd = '0;
    #100;
    spi_read(24'h000010, 8'hA5, 8'h3C, "post_rst");

    #200;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
